// File: rtl/serial_subtractor.sv
// serial_subtractor
// -----------------
// Bit-serial unsigned subtractor: computes a - b one bit per clock, LSB first,
// through a single registered borrow. A subtraction takes WIDTH cycles in RUN
// followed by a one-cycle DONE. A new start can be accepted in that DONE cycle,
// so back-to-back operations produce one result every WIDTH+1 cycles.
//
// Ports
//   clk     in   1      rising-edge clock
//   rst_n   in   1      asynchronous active-low reset
//   start   in   1      request; accepted in IDLE or DONE, ignored in RUN
//   a       in   WIDTH  minuend, captured on the accepting edge
//   b       in   WIDTH  subtrahend, captured on the accepting edge
//   busy    out  1      high while the operation is in RUN (registered)
//   done    out  1      one-cycle pulse when diff/borrow update (registered)
//   diff    out  WIDTH  (a - b) mod 2^WIDTH, held until the next completion
//   borrow  out  1      1 when a < b (unsigned), held with diff

module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;

  // Full-subtractor bit slice on the current operand LSBs.
  logic bit_s;
  logic br_nx_s;

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    br_d     = br_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;

    bit_s   = a_q[0] ^ b_q[0] ^ br_q;
    br_nx_s = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          res_d   = {WIDTH{1'b0}};
          br_d    = 1'b0;
          cnt_d   = {CW{1'b0}};
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        // Result fills from the MSB end so that after WIDTH shifts bit 0 of
        // the difference has landed in bit 0.
        res_d = {bit_s, res_q[WIDTH-1:1]};
        a_d   = {1'b0, a_q[WIDTH-1:1]};
        b_d   = {1'b0, b_q[WIDTH-1:1]};
        br_d  = br_nx_s;
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          diff_d   = {bit_s, res_q[WIDTH-1:1]};
          borrow_d = br_nx_s;
          state_d  = S_DONE;
        end else begin
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          res_d   = {WIDTH{1'b0}};
          br_d    = 1'b0;
          cnt_d   = {CW{1'b0}};
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // busy/done are flopped from the next state so they are glitch-free and
    // mutually exclusive by construction.
    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  // State, datapath and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_q      <= {WIDTH{1'b0}};
      b_q      <= {WIDTH{1'b0}};
      res_q    <= {WIDTH{1'b0}};
      br_q     <= 1'b0;
      cnt_q    <= {CW{1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      diff_q   <= {WIDTH{1'b0}};
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      br_q     <= br_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign diff   = diff_q;
  assign borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Testbench for serial_subtractor (WIDTH = 8). Expected results come from
// plain 8-bit arithmetic: diff = (a - b) mod 256, borrow = (a < b).

module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow;

  int checks;
  int errors;

  logic [W-1:0] held_diff;
  logic         held_borrow;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full operation with cycle-exact checks; optional stray start mid-RUN.
  task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input bit stray_start);
    logic [W-1:0] exp_d;
    logic         exp_b;
    exp_d = av - bv;
    exp_b = (av < bv);
    @(negedge clk);
    start = 1'b1;
    a = av;
    b = bv;
    @(posedge clk);  // acceptance edge E0
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < W; i++) begin
      chk("busy_run", 32'(busy), 32'd1);
      chk("done_run", 32'(done), 32'd0);
      chk("diff_hold_run", 32'(diff), 32'(held_diff));
      a = 8'($urandom);
      b = 8'($urandom);
      start = (stray_start && (i == 3)) ? 1'b1 : 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    chk("done_pulse", 32'(done), 32'd1);
    chk("busy_done", 32'(busy), 32'd0);
    chk("diff", 32'(diff), 32'(exp_d));
    chk("borrow", 32'(borrow), 32'(exp_b));
    held_diff = exp_d;
    held_borrow = exp_b;
    @(negedge clk);
    chk("done_drop", 32'(done), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
    chk("diff_hold_idle", 32'(diff), 32'(held_diff));
    chk("borrow_hold_idle", 32'(borrow), 32'(held_borrow));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    held_diff = '0;
    held_borrow = 1'b0;
    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;

    // Reset state
    #3;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_borrow", 32'(borrow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    do_op(8'h05, 8'h03, 1'b0);
    do_op(8'h03, 8'h05, 1'b0);
    do_op(8'h00, 8'h01, 1'b0);
    do_op(8'hA5, 8'hA5, 1'b0);
    do_op(8'hFF, 8'h00, 1'b0);
    do_op(8'h10, 8'h01, 1'b1);

    // Start held high: done every 9 cycles, no acceptance during RUN
    @(negedge clk);
    start = 1'b1;
    a = 8'h80;
    b = 8'h7F;
    @(posedge clk);
    for (int k = 0; k < 27; k++) begin
      @(negedge clk);
      chk("hold_done", 32'(done), ((k % 9) == 8) ? 32'd1 : 32'd0);
      chk("hold_busy", 32'(busy), ((k % 9) == 8) ? 32'd0 : 32'd1);
      if (k >= 8) begin
        held_diff = 8'h01;
        held_borrow = 1'b0;
      end else begin
        held_diff = held_diff;
      end
      chk("hold_diff", 32'(diff), 32'(held_diff));
      chk("hold_borrow", 32'(borrow), 32'(held_borrow));
    end
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("hold_end_busy", 32'(busy), 32'd0);

    // Asynchronous reset mid-RUN
    start = 1'b1;
    a = 8'h33;
    b = 8'h11;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_diff", 32'(diff), 32'd0);
    chk("arst_borrow", 32'(borrow), 32'd0);
    held_diff = '0;
    held_borrow = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    do_op(8'h05, 8'h03, 1'b0);

    // Randomized operations against the arithmetic model
    for (int r = 0; r < 20; r++) begin
      do_op(8'($urandom), 8'($urandom), (r % 4) == 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial N-bit subtractor computing `a - b` one bit per clock, LSB first, using a registered borrow. It is the inverse-operation companion to the team's adder blocks, for area-constrained datapaths where a parallel subtractor is too large. The block has a start/busy/done handshake. Results are held stable until the next accepted start.

## Interface
Parameters:
- `WIDTH`, default 8: operand and result width in bits; legal range 2–32.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: request a subtraction; sampled on the rising edge.
- `a`, input, WIDTH: minuend; captured on the edge that accepts `start`.
- `b`, input, WIDTH: subtrahend; captured on the edge that accepts `start`.
- `busy`, output, 1: high while an operation is in progress (state RUN).
- `done`, output, 1: one-cycle pulse when `diff` and `borrow` become valid.
- `diff`, output, WIDTH: `(a - b) mod 2^WIDTH`.
- `borrow`, output, 1: high when `a < b` as unsigned values.

## Operation
State machine: IDLE, RUN, DONE.

- **IDLE**
  - `start` = 1: capture `a` and `b` into internal shift registers, clear the borrow flip-flop, clear the bit counter, go to RUN.
- **RUN**, one bit per cycle:
  - `a0` and `b0` are the current LSBs of the shift registers; `br` is the borrow flip-flop.
  - `d = a0 ^ b0 ^ br`
  - `br_next = (~a0 & b0) | (~(a0 ^ b0) & br)`
  - Shift `d` into the MSB of the internal result register. Shift both operand registers right.
  - Counter increments. After the WIDTH-th bit, go to DONE.
  - `start` is ignored in RUN.
- **DONE**, one cycle:
  - `done` = 1.
  - `diff` and `borrow` were loaded from the internal result register and final `br` on the transition into DONE.
  - `start` = 1: accepted exactly as in IDLE (back-to-back), go to RUN. Otherwise go to IDLE.
- **Output holding**: `diff` and `borrow` change only on entry to DONE. They hold their values through IDLE and any later RUN until the next completion.
- **Counter**: width `$clog2(WIDTH+1)`. Terminal value WIDTH-1 in RUN triggers the transition to DONE.
- **Operand changes**: `a` and `b` may change freely after capture without affecting the operation in progress.

## Timing
- **Reset** (`rst_n` low, asynchronous, any state including mid-RUN): state IDLE, `busy` = 0, `done` = 0, `diff` = 0, `borrow` = 0, internal registers 0. The operation in progress is discarded.
- **Reset release**: first possible acceptance of `start` is the first rising edge with `rst_n` high.
- **Latency**: `start` accepted at edge E0.
  - `busy` is high from E0 until edge E0+WIDTH.
  - State DONE and `done` = 1 for exactly the cycle after edge E0+WIDTH.
  - `diff` and `borrow` are valid from edge E0+WIDTH.
- **Throughput**: with back-to-back starts, one result every WIDTH+1 cycles.
- **Simultaneous events**:
  - `start` asserted in the DONE cycle: `done` still pulses for that cycle; the next operation begins at the same edge that leaves DONE.
  - `start` held high continuously: one operation per WIDTH+1 cycles, with no extra acceptance during RUN.
- **Output timing**: `busy` and `done` are registered outputs, glitch-free, and never high simultaneously.

## Test plan
All scenarios use `WIDTH` = 8.

1. Reset, then `a`=5, `b`=3, `start` pulse → `done` 9 cycles after the start edge with `diff`=0x02, `borrow`=0; `busy` high for exactly 8 cycles.
2. `a`=3, `b`=5 → `diff`=0xFE, `borrow`=1. Then `a`=0x00, `b`=0x01 → `diff`=0xFF, `borrow`=1.
3. `a`=0xA5, `b`=0xA5 → `diff`=0x00, `borrow`=0. Then `a`=0xFF, `b`=0x00 → `diff`=0xFF, `borrow`=0.
4. Pulse `start` with `a`=0x10, `b`=0x01, change `a` and `b` during RUN, and pulse `start` mid-RUN → single `done`, `diff`=0x0F, `borrow`=0, no extra operation.
5. Hold `start` high with `a`=0x80, `b`=0x7F → `done` pulses every 9 cycles, each with `diff`=0x01, `borrow`=0; outputs stable between pulses.
6. Assert `rst_n` low at cycle 4 of RUN → `busy`, `done`, `diff` and `borrow` = 0 immediately (asynchronously). After release, a fresh 5-3 operation returns 0x02 with correct latency.
